// File: rtl/dds_spi_pkg.sv
// Shared definitions for the SPI parameter link: FSM states, register
// indices and frame geometry.
package dds_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] IDX_FRE_START = 2'd0;
    localparam logic [1:0] IDX_FRE_END   = 2'd1;
    localparam logic [1:0] IDX_STEP      = 2'd2;
    localparam logic [1:0] IDX_CYCLE     = 2'd3;

    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned ADDR_BITS  = 8;
    localparam int unsigned RW_BIT     = 7;

    // Address byte is legal only when the reserved bits 6:2 are clear.
    function automatic logic addr_ok(input logic [7:0] addr);
        return addr[6:2] == 5'b0;
    endfunction

endpackage

// File: rtl/spi_param_rx_if.sv
// SPI pin bundle between the MCU side (master) and the parameter receiver (slave).
interface spi_param_rx_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous pin, with a third flop for
// single-cycle rise/fall events.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {3{RST_VAL}};
        end else begin
            sr <= {sr[1:0], pin};
        end
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_param_rx.sv
// SPI mode-0 slave holding the four sweep parameters; oversampled in the clk
// domain, supports 40-bit write and read-back frames.
module spi_param_rx
    import dds_spi_pkg::*;
#(
    parameter logic [31:0] DEF_FRE_START = 32'd34300,
    parameter logic [31:0] DEF_FRE_END   = 32'd3430000,
    parameter logic [31:0] DEF_STEP      = 32'd8575,
    parameter logic [31:0] DEF_CYCLE     = 32'd93_750_000
) (
    input  logic          clk,
    input  logic          rst,
    spi_param_rx_if.slave spi,
    output logic [31:0]   fre_start,
    output logic [31:0]   fre_end,
    output logic [31:0]   fre_step,
    output logic [31:0]   cycle,
    output logic          param_upd,
    output logic [1:0]    param_idx,
    output logic          frame_err
);

    logic       sclk_level_unused;
    logic       sclk_rise, sclk_fall;
    logic       cs_level_unused;
    logic       cs_rise, cs_fall_raw, cs_fall;
    logic       mosi_s;
    logic [1:0] mosi_edges_unused;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi.spi_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi.spi_cs_n),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall_raw)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (spi.spi_mosi),
        .level (mosi_s),
        .rise  (mosi_edges_unused[0]),
        .fall  (mosi_edges_unused[1])
    );

    // The cs_n synchroniser resets high; if cs_n is already low at reset
    // release it would fake a fall, so events are masked until it has settled.
    logic [1:0] settle_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (settle_cnt != 2'd3) begin
            settle_cnt <= settle_cnt + 2'd1;
        end
    end
    assign cs_fall = cs_fall_raw & (settle_cnt == 2'd3);

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q;
    logic [31:0] shift_q;
    logic [7:0]  addr_q;
    logic [31:0] shadow_q;
    logic [5:0]  tx_cnt_q;
    logic        miso_q;

    logic [31:0] rx_word;
    logic [31:0] rd_sel;
    logic        in_frame, bit_take, addr_done, frame_done;
    logic        wr_frame, commit_wr, bad_wr, abort;

    always_comb begin
        rx_word    = {shift_q[30:0], mosi_s};
        in_frame   = (state_q == ST_ADDR) || (state_q == ST_DATA);
        bit_take   = in_frame && sclk_rise && !cs_rise;
        addr_done  = bit_take && (state_q == ST_ADDR) && (bit_cnt_q == 6'(ADDR_BITS - 1));
        frame_done = bit_take && (state_q == ST_DATA) && (bit_cnt_q == 6'(FRAME_BITS - 1));
        wr_frame   = frame_done && !addr_q[RW_BIT];
        commit_wr  = wr_frame && addr_ok(addr_q);
        bad_wr     = wr_frame && !addr_ok(addr_q);
        abort      = in_frame && cs_rise;
        case (rx_word[1:0])
            IDX_FRE_START: rd_sel = fre_start;
            IDX_FRE_END:   rd_sel = fre_end;
            IDX_STEP:      rd_sel = fre_step;
            default:       rd_sel = cycle;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_ADDR;
            ST_ADDR: begin
                if (cs_rise)        state_d = ST_IDLE;
                else if (addr_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cs_rise)         state_d = ST_IDLE;
                else if (frame_done) state_d = ST_DONE;
            end
            ST_DONE: if (cs_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            shadow_q  <= '0;
            tx_cnt_q  <= '0;
            miso_q    <= 1'b0;
            fre_start <= DEF_FRE_START;
            fre_end   <= DEF_FRE_END;
            fre_step  <= DEF_STEP;
            cycle     <= DEF_CYCLE;
            param_upd <= 1'b0;
            param_idx <= '0;
            frame_err <= 1'b0;
        end else begin
            param_upd <= 1'b0;
            frame_err <= abort || bad_wr;

            if ((state_q == ST_IDLE) && cs_fall) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (bit_take) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
                shift_q   <= rx_word;
            end

            if (addr_done) begin
                addr_q   <= rx_word[7:0];
                shadow_q <= (addr_ok(rx_word[7:0]) && rx_word[RW_BIT]) ? rd_sel : '0;
                tx_cnt_q <= '0;
            end

            // Read-back shifts on SPI fall events; zeros once all 32 bits are out.
            if (state_q != ST_DATA) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                if (tx_cnt_q < 6'd32) begin
                    miso_q   <= shadow_q[31];
                    shadow_q <= {shadow_q[30:0], 1'b0};
                    tx_cnt_q <= tx_cnt_q + 6'd1;
                end else begin
                    miso_q <= 1'b0;
                end
            end

            if (commit_wr) begin
                param_upd <= 1'b1;
                param_idx <= addr_q[1:0];
                case (addr_q[1:0])
                    IDX_FRE_START: fre_start <= rx_word;
                    IDX_FRE_END:   fre_end   <= rx_word;
                    IDX_STEP:      fre_step  <= rx_word;
                    default:       cycle     <= rx_word;
                endcase
            end
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_param_rx.sv
// Self-checking bench for spi_param_rx: bit-banged SPI master with a
// register-array reference model and pulse counters.
module tb_spi_param_rx;

    localparam logic [31:0] D_START = 32'd34300;
    localparam logic [31:0] D_END   = 32'd3430000;
    localparam logic [31:0] D_STEP  = 32'd8575;
    localparam logic [31:0] D_CYCLE = 32'd93_750_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fre_start, fre_end, fre_step, cycle;
    logic        param_upd, frame_err;
    logic [1:0]  param_idx;

    spi_param_rx_if bus ();

    spi_param_rx #(
        .DEF_FRE_START (D_START),
        .DEF_FRE_END   (D_END),
        .DEF_STEP      (D_STEP),
        .DEF_CYCLE     (D_CYCLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (bus),
        .fre_start (fre_start),
        .fre_end   (fre_end),
        .fre_step  (fre_step),
        .cycle     (cycle),
        .param_upd (param_upd),
        .param_idx (param_idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          upd_cnt = 0;
    int          err_cnt = 0;
    logic [1:0]  last_idx = '0;
    logic [31:0] model [4];
    logic [31:0] snap [4];
    logic        oe_seen;

    always @(negedge clk) begin
        if (param_upd === 1'b1) begin
            upd_cnt++;
            last_idx = param_idx;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic model_reset();
        model[0] = D_START;
        model[1] = D_END;
        model[2] = D_STEP;
        model[3] = D_CYCLE;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        wait_clks(5);
        oe_seen = bus.spi_miso_oe;
    endtask

    task automatic cs_high();
        wait_clks(5);
        bus.spi_cs_n = 1'b1;
        wait_clks(10);
    endtask

    // One mode-0 bit at sclk = clk/10; registers are snapshotted 5 clks after the rise.
    task automatic send_bit(input logic b, output logic m);
        bus.spi_mosi = b;
        wait_clks(5);
        m = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        wait_clks(5);
        snap[0] = fre_start;
        snap[1] = fre_end;
        snap[2] = fre_step;
        snap[3] = cycle;
        bus.spi_sclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] a, input logic [31:0] d, input int nbits,
                        output logic [31:0] rd);
        logic [39:0] frame;
        logic        m;
        frame = {a, d};
        rd = '0;
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            send_bit(frame[39 - i], m);
            if (i >= 8) rd = {rd[30:0], m};
        end
        cs_high();
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] cur [4];
        cur[0] = fre_start;
        cur[1] = fre_end;
        cur[2] = fre_step;
        cur[3] = cycle;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cur[i] !== model[i]) begin
                errors++;
                $display("FAIL %s reg%0d: got %h expected %h", tag, i, cur[i], model[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(6);
        model_reset();
        check_regs("reset");
        checks++;
        if (bus.spi_miso_oe !== 1'b0 || bus.spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got oe=%b miso=%b expected 0 0", bus.spi_miso_oe, bus.spi_miso);
        end
        checks++;
        if (param_upd !== 1'b0 || frame_err !== 1'b0 || param_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_strobes: got upd=%b err=%b idx=%0d expected 0 0 0",
                     param_upd, frame_err, param_idx);
        end
    endtask

    task automatic test_write_step();
        logic [31:0] rd;
        int u0, e0;
        u0 = upd_cnt; e0 = err_cnt;
        xfer(8'h02, 32'h0000_2183, 40, rd);
        model[2] = 32'h0000_2183;
        checks++;
        if (snap[2] !== 32'h0000_2183) begin
            errors++;
            $display("FAIL step_latency: got %h expected %h", snap[2], 32'h0000_2183);
        end
        checks++;
        if (oe_seen !== 1'b1) begin
            errors++;
            $display("FAIL oe_in_frame: got %b expected 1", oe_seen);
        end
        checks++;
        if (upd_cnt - u0 != 1 || last_idx !== 2'd2) begin
            errors++;
            $display("FAIL step_upd: got pulses=%0d idx=%0d expected 1 2", upd_cnt - u0, last_idx);
        end
        checks++;
        if (err_cnt != e0) begin
            errors++;
            $display("FAIL step_err: got %0d error pulses expected 0", err_cnt - e0);
        end
        check_regs("write_step");
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int u0;
        xfer(8'h03, 32'h0BEB_C200, 40, rd);
        model[3] = 32'h0BEB_C200;
        check_regs("write_cycle");
        u0 = upd_cnt;
        xfer(8'h83, $urandom, 40, rd);
        checks++;
        if (rd !== 32'h0BEB_C200) begin
            errors++;
            $display("FAIL readback: got %h expected %h", rd, 32'h0BEB_C200);
        end
        checks++;
        if (upd_cnt != u0) begin
            errors++;
            $display("FAIL read_no_upd: got %0d pulses expected 0", upd_cnt - u0);
        end
        check_regs("after_read");
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int u0, e0;
        u0 = upd_cnt; e0 = err_cnt;
        xfer(8'h00, $urandom, 20, rd);
        check_regs("abort");
        checks++;
        if (err_cnt - e0 != 1 || upd_cnt != u0) begin
            errors++;
            $display("FAIL abort_pulses: got err=%0d upd=%0d expected 1 0", err_cnt - e0, upd_cnt - u0);
        end
        xfer(8'h00, 32'h0000_ABCD, 40, rd);
        model[0] = 32'h0000_ABCD;
        check_regs("after_abort");
        checks++;
        if (upd_cnt - u0 != 1 || last_idx !== 2'd0) begin
            errors++;
            $display("FAIL after_abort_upd: got pulses=%0d idx=%0d expected 1 0", upd_cnt - u0, last_idx);
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd;
        int u0, e0;
        u0 = upd_cnt; e0 = err_cnt;
        xfer(8'h44, 32'hFFFF_FFFF, 40, rd);
        checks++;
        if (snap[0] !== model[0] || snap[1] !== model[1] || snap[2] !== model[2] || snap[3] !== model[3]) begin
            errors++;
            $display("FAIL bad_addr_regs: got %h %h %h %h expected %h %h %h %h",
                     snap[0], snap[1], snap[2], snap[3], model[0], model[1], model[2], model[3]);
        end
        checks++;
        if (err_cnt - e0 != 1 || upd_cnt != u0) begin
            errors++;
            $display("FAIL bad_addr_pulses: got err=%0d upd=%0d expected 1 0", err_cnt - e0, upd_cnt - u0);
        end
        xfer(8'hC4, $urandom, 40, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL bad_addr_read: got %h expected 00000000", rd);
        end
        check_regs("bad_addr");
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [1:0]  idx;
        logic        rw;
        int u0;
        for (int n = 0; n < 12; n++) begin
            idx = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            d   = $urandom;
            u0  = upd_cnt;
            xfer({rw, 5'b0, idx}, d, 40, rd);
            if (rw) begin
                checks++;
                if (rd !== model[idx] || upd_cnt != u0) begin
                    errors++;
                    $display("FAIL rand_read%0d idx%0d: got %h upd=%0d expected %h upd=0",
                             n, idx, rd, upd_cnt - u0, model[idx]);
                end
            end else begin
                model[idx] = d;
                checks++;
                if (upd_cnt - u0 != 1 || last_idx !== idx) begin
                    errors++;
                    $display("FAIL rand_upd%0d: got pulses=%0d idx=%0d expected 1 %0d",
                             n, upd_cnt - u0, last_idx, idx);
                end
            end
            check_regs("random");
        end
    endtask

    task automatic test_rst_mid_frame();
        logic [39:0] frame;
        logic [31:0] rd;
        logic        m;
        int u0, e0;
        frame = {8'h03, $urandom};
        cs_low();
        for (int i = 0; i < 20; i++) send_bit(frame[39 - i], m);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        model_reset();
        wait_clks(2);
        check_regs("rst_mid");
        u0 = upd_cnt; e0 = err_cnt;
        for (int i = 20; i < 40; i++) send_bit(frame[39 - i], m);
        cs_high();
        check_regs("rst_tail_ignored");
        checks++;
        if (upd_cnt != u0 || err_cnt != e0) begin
            errors++;
            $display("FAIL rst_tail_pulses: got upd=%0d err=%0d expected 0 0", upd_cnt - u0, err_cnt - e0);
        end
        frame[31:0] = $urandom;
        xfer(8'h03, frame[31:0], 40, rd);
        model[3] = frame[31:0];
        check_regs("after_rst_write");
    endtask

    initial begin
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        model_reset();
        test_reset();
        test_write_step();
        test_write_read();
        test_abort();
        test_bad_addr();
        test_random();
        test_rst_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_param_rx.md
Name: spi_param_rx

Overview:
SPI slave, mode 0, that terminates the STM32 parameter link and holds the four sweep parameters consumed by the sweep/key controller: start frequency word, end frequency word, step word and step-cycle count. It runs in the system clk domain and oversamples the asynchronous SPI pins. It supports write and read-back transactions, and gives a one-cycle update strobe per committed write. It sits between the MCU pins and the sweep controller's SPI_fre_start, SPI_fre_end, SPI_step and SPI_cycle inputs.

Parameters:
DEF_FRE_START, 32'd34300, reset value of fre_start
DEF_FRE_END, 32'd3430000, reset value of fre_end
DEF_STEP, 32'd8575, reset value of fre_step
DEF_CYCLE, 32'd93_750_000, reset value of cycle

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency
rst  in  1  asynchronous, active-high reset
spi_sclk  in  1  SPI clock from the MCU; async; idles low
spi_cs_n  in  1  chip select, active low; async
spi_mosi  in  1  master out, slave in; async
spi_miso  out  1  slave out, master in
spi_miso_oe  out  1  MISO output enable; the top level tri-states MISO when this is 0
fre_start  out  32  start frequency word
fre_end  out  32  end frequency word
fre_step  out  32  step frequency word
cycle  out  32  step period in clk cycles
param_upd  out  1  one-cycle pulse when a write commits
param_idx  out  2  index of the register written; valid while param_upd is high
frame_err  out  1  one-cycle pulse when a frame is aborted or malformed

Behaviour:
- Synchronisation: sclk, cs_n and mosi each pass through 2 flops. A third sclk/cs_n flop supplies edge detection. A "rise" or "fall" event is one clk cycle, 3 clks after the pin edge. mosi is sampled from its synchronised value on the rise event.
- Frame format, 40 bits, MSB first:
  - Byte A: bit7 = R/W (1 = read); bits6:2 must be 0; bits1:0 = register index (0 fre_start, 1 fre_end, 2 fre_step, 3 cycle).
  - Then 32 data bits.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE -> ADDR on cs_n fall event. Clear the bit counter (6 bits) and the shift register.
  - ADDR: shift one bit per rise event. After the 8th rise, latch the address byte, then go to DATA.
    - If the address is valid and R/W = 1, load the read shadow with the selected register at that same clk edge.
  - DATA: shift one bit per rise event. On the 40th rise, go to DONE.
    - For a valid write, at the clk edge after the 40th rise: update the selected register, pulse param_upd, drive param_idx.
  - DONE: ignore further sclk edges. On cs_n rise event go to IDLE.
- cs_n rise event in ADDR or DATA (fewer than 40 bits received):
  - No register changes; frame_err pulses one cycle; go to IDLE.
- Invalid address (bits6:2 nonzero):
  - A write is discarded and frame_err pulses when the 40th bit arrives.
  - A read returns all zeros.
- MISO:
  - spi_miso_oe = 1 only while the FSM is not IDLE.
  - spi_miso = 0 in ADDR.
  - On the first fall event after entering DATA, present shadow[31]. Each later fall event shifts out the next bit.
  - After 32 bits have been shifted out, spi_miso = 0.
- Reads have no side effects; param_upd is not pulsed.
- Registers hold their value until the next valid write. They change only on the single commit edge, so consumers see all 32 bits switch together.
- Reset, including mid-frame: FSM goes to IDLE and the bit counter clears. Outputs take these values:
  - fre_start = DEF_FRE_START, fre_end = DEF_FRE_END, fre_step = DEF_STEP, cycle = DEF_CYCLE.
  - param_upd = 0, param_idx = 0, frame_err = 0, spi_miso = 0, spi_miso_oe = 0.
  - Synchroniser flops reset to the idle pin levels: sclk 0, cs_n 1, mosi 0.
  - A frame in flight when rst deasserts is not recognised until the next cs_n fall.
- A cs_n fall event while not in IDLE cannot occur without a preceding rise. If rise and fall arrive in back-to-back cycles, both are handled in order because the events are one cycle apart.
- No value checking is done on any parameter, including fre_start > fre_end and cycle = 0; that is the consumer's responsibility.

Decomposition:
- Package dds_spi_pkg holds:
  - the FSM state enum
  - index constants IDX_FRE_START, IDX_FRE_END, IDX_STEP, IDX_CYCLE
  - FRAME_BITS = 40 and ADDR_BITS = 8
  - the RW bit position
- Sub-module spi_pin_sync: 2-flop synchroniser plus rise/fall event detection for one pin. Instantiated for sclk and cs_n; mosi uses the synchroniser only.

Test Plan:
- Release rst, no SPI activity -> fre_start=34300, fre_end=3430000, fre_step=8575, cycle=93750000; miso_oe=0.
- Write frame 0x02, 0x0000_2183 at sclk=clk/10 -> fre_step=0x2183 within 5 clks of the 40th rise; one param_upd pulse with param_idx=2; other registers unchanged.
- Write 0x03, 0x0BEB_C200, then read frame 0x83 -> MISO returns 0x0BEB_C200 MSB first, sampled on sclk rises; no param_upd on the read.
- Write frame to index 0 with cs_n raised after 20 bits -> fre_start stays 34300; frame_err pulses once; the next full write of 0x0000_ABCD succeeds.
- Address 0x44 (bits6:2 nonzero) write 0xFFFF_FFFF -> no register change, frame_err pulses; read 0xC4 returns 0.
- Assert rst during the DATA phase of a write to cycle -> cycle=93750000 after reset; frame ignored until the next cs_n fall.
